// File: rtl/cnt_pkg.sv
// Shared types and configuration checks for the parametrised up/down counter.
package cnt_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

  localparam int unsigned CNT_MIN_WIDTH = 2;
  localparam int unsigned CNT_MAX_WIDTH = 32;

  // True when width, modulus and reset value form a usable counter.
  function automatic bit cnt_cfg_ok(input int unsigned     width,
                                    input longint unsigned max_val,
                                    input longint unsigned rst_val);
    longint unsigned lim;
    if (width < CNT_MIN_WIDTH || width > CNT_MAX_WIDTH) return 1'b0;
    lim = (64'd1 << width) - 64'd1;
    return (max_val >= 64'd1) && (max_val <= lim) && (rst_val <= max_val);
  endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-count step: one count in the chosen direction, with
// boundary detection and wrap/saturate handling, computed at WIDTH+1 bits.
module cnt_next_val
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 9
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_dir_e         dir,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_c,
  output logic             at_bound_c,
  output logic             wrap_c
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  assign cnt_ext = {1'b0, count};
  assign inc     = cnt_ext + (WIDTH+1)'(1);
  assign dec     = cnt_ext - (WIDTH+1)'(1);

  // Up boundary: the increment passes MAX_VAL; down boundary: the decrement borrows.
  always_comb begin
    next_c     = count;
    at_bound_c = 1'b0;
    wrap_c     = 1'b0;
    if (dir == CNT_UP) begin
      at_bound_c = (inc > MAX_EXT);
      if (!at_bound_c) begin
        next_c = inc[WIDTH-1:0];
      end else if (mode == CNT_WRAP) begin
        next_c = '0;
        wrap_c = 1'b1;
      end
    end else begin
      at_bound_c = dec[WIDTH];
      if (!at_bound_c) begin
        next_c = dec[WIDTH-1:0];
      end else if (mode == CNT_WRAP) begin
        next_c = MAX_W;
        wrap_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with clamped load, wrap/saturate mode, cascade tc
// and a registered wrap pulse. CNT_STICKY_FLAGS_EN adds sticky ovf/udf flags.
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 9,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up_down,
  input  logic             sat_mode,
`ifdef CNT_STICKY_FLAGS_EN
  input  logic             flag_clr,
  output logic             ovf,
  output logic             udf,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam bit               CFG_OK = cnt_cfg_ok(WIDTH, 64'(MAX_VAL), 64'(RST_VAL));
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("param_updown_counter: illegal WIDTH/MAX_VAL/RST_VAL combination");
    end
  endgenerate

  cnt_dir_e         dir;
  cnt_mode_e        mode;
  logic [WIDTH-1:0] step_val;
  logic             at_bound;
  logic             step_wrap;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

  assign dir  = cnt_dir_e'(up_down);
  assign mode = cnt_mode_e'(sat_mode);

  cnt_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count      (count),
    .dir        (dir),
    .mode       (mode),
    .next_c     (step_val),
    .at_bound_c (at_bound),
    .wrap_c     (step_wrap)
  );

  // Loads above the modulus clamp so count never leaves 0..MAX_VAL.
  assign load_val = ({1'b0, data} > {1'b0, MAX_W}) ? MAX_W : data;
  assign tc       = en & ~load & at_bound;

  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = step_val;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= RST_W;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

`ifdef CNT_STICKY_FLAGS_EN
  logic ovf_set;
  logic udf_set;

  // A boundary step sets its flag regardless of mode; set beats clear.
  assign ovf_set = tc & up_down;
  assign udf_set = tc & ~up_down;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~flag_clr);
      udf <= udf_set | (udf & ~flag_clr);
    end
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed table-driven bench for param_updown_counter plus cascade and 8-bit sequences.
module tb_param_updown_counter;

  typedef struct {
    logic       rst, en, load;
    logic [3:0] data;
    logic       up, sat, clr, tc_chk, tc;
    logic [3:0] cnt;
    logic       wrap, ovf, udf;
  } vec_t;

  localparam int NVEC = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main 4-bit, MAX_VAL=9 instance
  logic       rst, en, load, up_down, sat_mode, flag_clr;
  logic [3:0] data;
  logic [3:0] count;
  logic       tc, wrap;
`ifdef CNT_STICKY_FLAGS_EN
  logic       ovf, udf;
`endif

  // Two-stage decade cascade
  logic       c_rst, c_en;
  logic [3:0] lsb_count, msb_count;
  logic       lsb_tc, lsb_wrap, msb_tc, msb_wrap;
`ifdef CNT_STICKY_FLAGS_EN
  logic       lsb_ovf, lsb_udf, msb_ovf, msb_udf;
`endif

  // 8-bit full-range instance
  logic       w_rst, w_en, w_load;
  logic [7:0] w_data, w_count;
  logic       w_tc, w_wrap;
`ifdef CNT_STICKY_FLAGS_EN
  logic       w_ovf, w_udf;
`endif

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .up_down(up_down), .sat_mode(sat_mode),
`ifdef CNT_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .ovf(ovf), .udf(udf),
`endif
    .count(count), .tc(tc), .wrap(wrap)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) u_lsb (
    .clk(clk), .rst(c_rst), .en(c_en), .load(1'b0), .data(4'd0),
    .up_down(1'b1), .sat_mode(1'b0),
`ifdef CNT_STICKY_FLAGS_EN
    .flag_clr(1'b0), .ovf(lsb_ovf), .udf(lsb_udf),
`endif
    .count(lsb_count), .tc(lsb_tc), .wrap(lsb_wrap)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) u_msb (
    .clk(clk), .rst(c_rst), .en(lsb_tc), .load(1'b0), .data(4'd0),
    .up_down(1'b1), .sat_mode(1'b0),
`ifdef CNT_STICKY_FLAGS_EN
    .flag_clr(1'b0), .ovf(msb_ovf), .udf(msb_udf),
`endif
    .count(msb_count), .tc(msb_tc), .wrap(msb_wrap)
  );

  param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .RST_VAL(0)) u_wide (
    .clk(clk), .rst(w_rst), .en(w_en), .load(w_load), .data(w_data),
    .up_down(1'b1), .sat_mode(1'b0),
`ifdef CNT_STICKY_FLAGS_EN
    .flag_clr(1'b0), .ovf(w_ovf), .udf(w_udf),
`endif
    .count(w_count), .tc(w_tc), .wrap(w_wrap)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, e, l, input logic [3:0] d,
                              input logic u, s, c, tchk, t, input logic [3:0] cn,
                              input logic w, o, ud);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.data = d; v.up = u; v.sat = s; v.clr = c;
    v.tc_chk = tchk; v.tc = t; v.cnt = cn; v.wrap = w; v.ovf = o; v.udf = ud;
    return v;
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; data = 4'd0; up_down = 1'b1; sat_mode = 1'b0;
    flag_clr = 1'b0;
    c_rst = 1'b0; c_en = 1'b0;
    w_rst = 1'b0; w_en = 1'b0; w_load = 1'b0; w_data = 8'd0;

    //            rst en ld data  up sat clr chk tc  cnt   wr ovf udf
    tbl[0]  = mk(0, 1, 0, 4'd0,  1, 0,  0,  0, 0, 4'd0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 4'd0,  1, 0,  0,  1, 0, 4'd0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 4'd0,  1, 0,  0,  1, 0, 4'd1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      tbl[2+k] = mk(1, 1, 0, 4'd0, 1, 0, 0, 1, 0, 4'(k+1), 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 4'd0,  1, 0,  0,  1, 1, 4'd0, 1, 1, 0);
    tbl[12] = mk(1, 1, 0, 4'd0,  1, 0,  0,  1, 0, 4'd1, 0, 1, 0);
    tbl[13] = mk(1, 1, 1, 4'd2,  1, 0,  0,  1, 0, 4'd2, 0, 1, 0);
    tbl[14] = mk(1, 1, 0, 4'd0,  0, 1,  0,  1, 0, 4'd1, 0, 1, 0);
    tbl[15] = mk(1, 1, 0, 4'd0,  0, 1,  0,  1, 0, 4'd0, 0, 1, 0);
    tbl[16] = mk(1, 1, 0, 4'd0,  0, 1,  0,  1, 1, 4'd0, 0, 1, 1);
    tbl[17] = mk(1, 1, 0, 4'd0,  0, 1,  0,  1, 1, 4'd0, 0, 1, 1);
    tbl[18] = mk(1, 0, 0, 4'd0,  0, 1,  1,  1, 0, 4'd0, 0, 0, 0);
    tbl[19] = mk(1, 1, 0, 4'd0,  0, 0,  0,  1, 1, 4'd9, 1, 0, 1);
    tbl[20] = mk(1, 0, 0, 4'd0,  0, 0,  0,  1, 0, 4'd9, 0, 0, 1);
    tbl[21] = mk(1, 1, 1, 4'hC,  1, 0,  0,  1, 0, 4'd9, 0, 0, 1);
    tbl[22] = mk(1, 1, 1, 4'd5,  1, 0,  0,  1, 0, 4'd5, 0, 0, 1);
    tbl[23] = mk(1, 1, 0, 4'd0,  1, 0,  0,  1, 0, 4'd6, 0, 0, 1);
    tbl[24] = mk(1, 0, 1, 4'd9,  1, 0,  0,  1, 0, 4'd9, 0, 0, 1);
    tbl[25] = mk(1, 1, 0, 4'd0,  1, 1,  0,  1, 1, 4'd9, 0, 1, 1);
    tbl[26] = mk(0, 1, 0, 4'd0,  1, 0,  0,  1, 1, 4'd0, 0, 0, 0);
    tbl[27] = mk(1, 1, 0, 4'd0,  1, 0,  0,  1, 0, 4'd1, 0, 0, 0);
    tbl[28] = mk(1, 1, 0, 4'd0,  0, 1,  0,  1, 0, 4'd0, 0, 0, 0);
    tbl[29] = mk(1, 1, 0, 4'd0,  0, 1,  1,  1, 1, 4'd0, 0, 0, 1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; data = tbl[i].data;
      up_down = tbl[i].up; sat_mode = tbl[i].sat; flag_clr = tbl[i].clr;
      #1;
      if (tbl[i].tc_chk) check($sformatf("v%0d tc", i), 32'(tc), 32'(tbl[i].tc));
      @(posedge clk); #1;
      check($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("v%0d wrap", i), 32'(wrap), 32'(tbl[i].wrap));
`ifdef CNT_STICKY_FLAGS_EN
      check($sformatf("v%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("v%0d udf", i), 32'(udf), 32'(tbl[i].udf));
`endif
    end

    // Decade cascade: 100 enabled cycles from 00 return to 00.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      c_rst = 1'b1; c_en = 1'b1;
      #1;
      check($sformatf("casc%0d msb_tc", k), 32'(msb_tc),
            32'(((k % 10) == 9) && (((k / 10) % 10) == 9)));
      @(posedge clk); #1;
      check($sformatf("casc%0d lsb", k), 32'(lsb_count), 32'((k + 1) % 10));
      check($sformatf("casc%0d msb", k), 32'(msb_count), 32'(((k + 1) / 10) % 10));
    end
    check("casc lsb_wrap", 32'(lsb_wrap), 32'd1);
    check("casc msb_wrap", 32'(msb_wrap), 32'd1);
`ifdef CNT_STICKY_FLAGS_EN
    check("casc msb_ovf", 32'(msb_ovf), 32'd1);
    check("casc lsb_udf", 32'(lsb_udf), 32'd0);
`endif
    @(negedge clk);
    c_en = 1'b0;

    // 8-bit full range: 254 -> 255 -> 0 with a wrap pulse.
    @(negedge clk);
    w_rst = 1'b1; w_load = 1'b1; w_data = 8'd254; w_en = 1'b0;
    @(posedge clk); #1;
    check("wide load", 32'(w_count), 32'd254);
    @(negedge clk);
    w_load = 1'b0; w_en = 1'b1;
    #1;
    check("wide tc@254", 32'(w_tc), 32'd0);
    @(posedge clk); #1;
    check("wide count 255", 32'(w_count), 32'd255);
    check("wide wrap@255", 32'(w_wrap), 32'd0);
    @(negedge clk); #1;
    check("wide tc@255", 32'(w_tc), 32'd1);
    @(posedge clk); #1;
    check("wide count 0", 32'(w_count), 32'd0);
    check("wide wrap pulse", 32'(w_wrap), 32'd1);
`ifdef CNT_STICKY_FLAGS_EN
    check("wide ovf", 32'(w_ovf), 32'd1);
    check("wide udf", 32'(w_udf), 32'd0);
`endif
    @(negedge clk);
    w_en = 1'b0;
    @(posedge clk); #1;
    check("wide hold", 32'(w_count), 32'd0);
    check("wide wrap drop", 32'(w_wrap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
